imm_encoder: RTL and testbench
==============================

Name: imm_encoder

Overview:
Instruction encoder: the inverse of the immediate-generation path. Takes decoded fields plus a 32-bit immediate and packs them into a 32-bit RV32I instruction word, with an immediate range/alignment check. Sits between the test/program-loader logic and instruction memory; uses valid/ready on both sides and a registered output. The optional expansion mode turns out-of-range `li`-style ADDIs into a LUI+ADDI pair.

Parameters:
- NONE, -, no parameters; the width is fixed at 32 bits (RV32I).

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  input fields valid
- in_ready  output  1  encoder can accept
- i_type  input  3  0=I, 1=S, 2=B, 3=U, 4=J, 5-7 illegal
- opcode  input  7  instruction bits [6:0]
- rd  input  5  destination register (I/U/J)
- rs1  input  5  source 1 (I/S/B)
- rs2  input  5  source 2 (S/B)
- funct3  input  3  (I/S/B)
- imm  input  32  full immediate, two's complement
- out_valid  output  1  out_instr valid
- out_ready  input  1  consumer accepts
- out_instr  output  32  encoded instruction
- out_err  output  1  immediate not representable, or illegal i_type; qualified by out_valid

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous, active-low, on rst_n.
- Reset values: out_valid=0, out_instr=0, out_err=0, FSM=EMPTY.
- Handshake:
  - Input transfer occurs when in_valid & in_ready.
  - Output transfer occurs when out_valid & out_ready.
  - in_ready = (state==EMPTY) | (state==FULL & out_ready). It is combinational from out_ready and state only, never from in_valid.
- Latency and throughput: 1 cycle from input accept to out_valid. Full throughput is 1 word/cycle.
- Output stability: out_instr and out_err hold stable while out_valid & !out_ready.
- Packing, by i_type:
  - I: {imm[11:0], rs1, funct3, rd, opcode}
  - S: {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}
  - B: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode}
  - U: {imm[31:12], rd, opcode}
  - J: {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode}
  - 5-7: out_instr=0, out_err=1.
- Range check (out_err=1 on violation; the word is still packed from the truncated bits):
  - I, S: -2048 <= imm <= 2047.
  - B: -4096 <= imm <= 4094 and imm[0]==0.
  - U: imm[11:0]==0.
  - J: -1048576 <= imm <= 1048574 and imm[0]==0.
- FSM states: EMPTY, FULL, FIRST (FIRST exists only with the optional feature).
  - EMPTY + accept -> FULL, or FIRST if expanding.
  - FULL & out_ready: accept -> FULL/FIRST; no accept -> EMPTY.
  - FULL & !out_ready -> FULL (hold).
  - FIRST & out_ready -> FULL, loading the second word from the latched rd/lo12. in_ready=0 while in FIRST.
- Simultaneous pop and push in FULL: the new word replaces the old in the same edge, with no bubble.
- Reset mid-operation: any pending word, including a pending second word of a pair, is discarded. out_valid drops asynchronously.

Optional Feature:
- Macro: IMM_EXPAND_EN.
- Defined: an input with i_type=0, opcode=7'b0010011, funct3=000, rs1=0, rd!=0, and imm outside [-2048,2047] is expanded instead of flagged. It emits two words, both with out_err=0:
  - LUI rd, hi, where hi=(imm+32'h800)[31:12];
  - ADDI rd, rd, imm[11:0].
  - Those two words use state FIRST; in_ready stays low until the second word is presented.
- Not defined: FIRST is not built; such inputs encode as normal I-type with out_err=1.

Test Plan:
- i_type=0, op=0010011, rd=1, rs1=0, f3=0, imm=10 -> out_instr=32'h00A00093, err=0, one cycle after accept.
- i_type=1, op=0100011, rs1=1, rs2=2, f3=010, imm=8 -> 32'h0020A423. i_type=2, op=1100011, rs1=1, rs2=2, f3=000, imm=-4 -> 32'hFE208EE3.
- i_type=4, op=1101111, rd=1, imm=2048 -> 32'h001000EF. Same with imm=2049 -> err=1 (misaligned).
- i_type=0, addi rd=5, rs1=0, imm=32'h12345:
  - Without IMM_EXPAND_EN -> err=1.
  - With IMM_EXPAND_EN -> 32'h000122B7, then 32'h34528293, err=0; in_ready=0 between the two words.
- Back-to-back stream of 4 words with out_ready held low 3 cycles mid-stream -> out_instr stable while stalled, no word lost or duplicated, in_ready tracks out_ready.
- i_type=6 -> out_instr=0, err=1. Assert rst_n low while a word is pending -> out_valid=0 immediately, and the first word after release is the next accepted input.

Source files
------------

// File: rtl/imm_encoder.sv
// Purpose : packs decoded RV32I fields plus a 32-bit immediate into an instruction word, flagging
//           immediates that the chosen format cannot represent; optional li-style ADDI expansion.
// Latency : 1 cycle from input accept to out_valid; 1 word/cycle sustained.
// Backpressure: single output register; in_ready = EMPTY | (FULL & out_ready), never from in_valid.
//
// Ports:
//   clk, rst_n                  clock (rising edge), asynchronous active-low reset
//   in_valid / in_ready         input handshake for i_type, opcode, rd, rs1, rs2, funct3, imm
//   out_valid / out_ready       output handshake for out_instr, out_err
//   out_err                     immediate out of range / misaligned, or illegal i_type
//
// Build option: IMM_EXPAND_EN -- when defined, an out-of-range "addi rd, x0, imm" (rd != 0) is
// emitted as LUI rd, hi followed by ADDI rd, rd, lo12 instead of being flagged.
module imm_encoder (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  i_type,
  input  logic [6:0]  opcode,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  funct3,
  input  logic [31:0] imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic        out_err
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
`ifdef IMM_EXPAND_EN
    FIRST = 2'd2,
`endif
    FULL  = 2'd1
  } state_t;

  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] OP_LUI = 7'b0110111;

  state_t      state, state_d;
  logic [31:0] instr_d;
  logic        err_d;
  logic [31:0] enc_instr;
  logic        enc_err;
  logic        accept;

  // A signed value fits in N bits exactly when bits [31:N-1] are all equal.
  logic fits12, fits13, fits21;
  assign fits12 = (&imm[31:11]) | ~(|imm[31:11]);
  assign fits13 = (&imm[31:12]) | ~(|imm[31:12]);
  assign fits21 = (&imm[31:20]) | ~(|imm[31:20]);

  always_comb begin
    enc_instr = '0;
    enc_err   = 1'b0;
    case (i_type)
      3'd0: begin
        enc_instr = {imm[11:0], rs1, funct3, rd, opcode};
        enc_err   = ~fits12;
      end
      3'd1: begin
        enc_instr = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
        enc_err   = ~fits12;
      end
      3'd2: begin
        enc_instr = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
        enc_err   = ~fits13 | imm[0];
      end
      3'd3: begin
        enc_instr = {imm[31:12], rd, opcode};
        enc_err   = |imm[11:0];
      end
      3'd4: begin
        enc_instr = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
        enc_err   = ~fits21 | imm[0];
      end
      default: begin
        enc_instr = '0;
        enc_err   = 1'b1;
      end
    endcase
  end

  assign in_ready  = (state == EMPTY) | ((state == FULL) & out_ready);
  assign accept    = in_valid & in_ready;
  assign out_valid = (state != EMPTY);

`ifdef IMM_EXPAND_EN
  logic        expand;
  logic [19:0] lui_hi;
  logic [4:0]  pend_rd;
  logic [11:0] pend_lo12;

  assign expand = (i_type == 3'd0) & (opcode == OP_IMM) & (funct3 == 3'b000) &
                  (rs1 == 5'd0) & (rd != 5'd0) & ~fits12;
  // ADDI sign-extends lo12, so the upper part is rounded: (imm + 0x800) >> 12.
  assign lui_hi = imm[31:12] + {19'd0, imm[11]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_rd   <= '0;
      pend_lo12 <= '0;
    end else if (accept && expand) begin
      pend_rd   <= rd;
      pend_lo12 <= imm[11:0];
    end
  end
`endif

  always_comb begin
    state_d = state;
    instr_d = out_instr;
    err_d   = out_err;
    if (accept) begin
      // Covers both a fresh load from EMPTY and pop+push in FULL with no bubble.
`ifdef IMM_EXPAND_EN
      if (expand) begin
        state_d = FIRST;
        instr_d = {lui_hi, rd, OP_LUI};
        err_d   = 1'b0;
      end else begin
        state_d = FULL;
        instr_d = enc_instr;
        err_d   = enc_err;
      end
`else
      state_d = FULL;
      instr_d = enc_instr;
      err_d   = enc_err;
`endif
    end else if ((state == FULL) && out_ready) begin
      state_d = EMPTY;
`ifdef IMM_EXPAND_EN
    end else if ((state == FIRST) && out_ready) begin
      state_d = FULL;
      instr_d = {pend_lo12, pend_rd, 3'b000, pend_rd, OP_IMM};
      err_d   = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= EMPTY;
      out_instr <= '0;
      out_err   <= 1'b0;
    end else begin
      state     <= state_d;
      out_instr <= instr_d;
      out_err   <= err_d;
    end
  end

endmodule

// File: tb/tb_imm_encoder.sv
module tb_imm_encoder;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  i_type;
  logic [6:0]  opcode;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [2:0]  funct3;
  logic [31:0] imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic        out_err;

  imm_encoder dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .i_type(i_type), .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2),
    .funct3(funct3), .imm(imm),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_err(out_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic [31:0] w;
    logic        e;
  } exp_t;

  exp_t mq[$];     // words the encoder owes the consumer, oldest first
  bit   m_push;    // model accepted an input on the most recent edge

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Encoding straight from the format tables, range checks done as integer arithmetic.
  function automatic exp_t enc_model(input logic [2:0] t, input logic [6:0] op,
                                     input logic [4:0] d, input logic [4:0] s1,
                                     input logic [4:0] s2, input logic [2:0] f3,
                                     input logic [31:0] im);
    exp_t   r;
    longint v;
    v = $signed(im);
    r.w = '0;
    r.e = 1'b1;
    case (t)
      3'd0: begin r.w = {im[11:0], s1, f3, d, op};            r.e = (v < -2048) || (v > 2047); end
      3'd1: begin r.w = {im[11:5], s2, s1, f3, im[4:0], op};  r.e = (v < -2048) || (v > 2047); end
      3'd2: begin
        r.w = {im[12], im[10:5], s2, s1, f3, im[4:1], im[11], op};
        r.e = (v < -4096) || (v > 4094) || (im[0] == 1'b1);
      end
      3'd3: begin r.w = {im[31:12], d, op};                   r.e = (im[11:0] != 12'd0); end
      3'd4: begin
        r.w = {im[20], im[10:1], im[11], im[19:12], d, op};
        r.e = (v < -1048576) || (v > 1048574) || (im[0] == 1'b1);
      end
      default: begin r.w = '0; r.e = 1'b1; end
    endcase
    return r;
  endfunction

  task automatic model_push();
    exp_t   r;
    longint v;
    v = $signed(imm);
`ifdef IMM_EXPAND_EN
    if (i_type == 3'd0 && opcode == 7'h13 && funct3 == 3'd0 && rs1 == 5'd0 && rd != 5'd0 &&
        (v < -2048 || v > 2047)) begin
      longint      h;
      logic [63:0] hb;
      h  = (v + 2048) >>> 12;
      hb = h;
      r.w = {hb[19:0], rd, 7'h37};
      r.e = 1'b0;
      mq.push_back(r);
      r.w = {imm[11:0], rd, 3'd0, rd, 7'h13};
      r.e = 1'b0;
      mq.push_back(r);
      return;
    end
`endif
    r = enc_model(i_type, opcode, rd, rs1, rs2, funct3, imm);
    mq.push_back(r);
  endtask

  // Transaction-level model: the register holds at most one word, or a pair when expanding.
  always @(posedge clk) begin
    bit pop, rdy, push;
    if (rst_n) begin
      pop  = (mq.size() > 0) && out_ready;
      rdy  = (mq.size() == 0) || (mq.size() == 1 && out_ready);
      push = in_valid && rdy;
      if (pop) void'(mq.pop_front());
      if (push) model_push();
      m_push = push;
    end else begin
      m_push = 1'b0;
    end
  end

  always @(negedge rst_n) mq.delete();

  // Compare every cycle, half a period away from the active edge.
  logic        prev_stall = 1'b0;
  logic [31:0] prev_w     = '0;
  always @(negedge clk) begin
    logic ev, er;
    ev = (mq.size() > 0);
    er = (mq.size() == 0) || (mq.size() == 1 && out_ready);
    chk("out_valid", {31'd0, out_valid}, {31'd0, ev});
    chk("in_ready",  {31'd0, in_ready},  {31'd0, er});
    if (ev && out_valid) begin
      chk("out_instr", out_instr, mq[0].w);
      chk("out_err", {31'd0, out_err}, {31'd0, mq[0].e});
    end
    if (prev_stall && out_valid) chk("stall_hold", out_instr, prev_w);
    prev_stall = out_valid && !out_ready;
    prev_w     = out_instr;
  end

  task automatic send(input logic [2:0] t, input logic [6:0] op, input logic [4:0] d,
                      input logic [4:0] s1, input logic [4:0] s2, input logic [2:0] f3,
                      input logic [31:0] im);
    bit done;
    done     = 1'b0;
    i_type   = t;  opcode = op; rd = d; rs1 = s1; rs2 = s2; funct3 = f3; imm = im;
    in_valid = 1'b1;
    for (int i = 0; i < 50 && !done; i++) begin
      @(posedge clk);
      #1;
      if (m_push) done = 1'b1;
    end
    if (!done) begin
      n_chk++;
      n_fail++;
      $display("FAIL send_timeout: input not accepted within 50 cycles, expected accept");
    end
  endtask

  // Single word with a hand-computed expectation, checked one cycle after accept.
  task automatic one(input string nm, input logic [2:0] t, input logic [6:0] op,
                     input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
                     input logic [2:0] f3, input logic [31:0] im,
                     input logic [31:0] ew, input logic ee);
    send(t, op, d, s1, s2, f3, im);
    in_valid = 1'b0;
    @(negedge clk);
    chk({nm, "_vld"},   {31'd0, out_valid}, 32'd1);
    chk({nm, "_instr"}, out_instr, ew);
    chk({nm, "_err"},   {31'd0, out_err}, {31'd0, ee});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    exp_t p;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    i_type = '0; opcode = '0; rd = '0; rs1 = '0; rs2 = '0; funct3 = '0; imm = '0;

    // Pin the model against hand-encoded words.
    p = enc_model(3'd0, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 32'd10);
    chk("pin_i", p.w, 32'h00A00093);
    p = enc_model(3'd2, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, -32'sd4);
    chk("pin_b", p.w, 32'hFE208EE3);
    p = enc_model(3'd4, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 32'd2049);
    chk("pin_j_err", {31'd0, p.e}, 32'd1);

    @(negedge clk);
    chk("rst_vld",   {31'd0, out_valid}, 32'd0);
    chk("rst_instr", out_instr, 32'd0);
    chk("rst_err",   {31'd0, out_err}, 32'd0);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;

    one("i_addi",  3'd0, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 32'd10,        32'h00A00093, 1'b0);
    one("s_sw",    3'd1, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 32'd8,         32'h0020A423, 1'b0);
    one("b_neg",   3'd2, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 32'hFFFFFFFC,  32'hFE208EE3, 1'b0);
    one("b_max",   3'd2, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 32'd4094,      32'h7E208FE3, 1'b0);
    one("b_over",  3'd2, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 32'd4096,      32'h80208063, 1'b1);
    one("j_2048",  3'd4, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 32'd2048,      32'h001000EF, 1'b0);
    one("j_odd",   3'd4, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 32'd2049,      32'h001000EF, 1'b1);
    one("u_lui",   3'd3, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 32'h12345000,  32'h123452B7, 1'b0);
    one("u_low",   3'd3, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 32'h12345001,  32'h123452B7, 1'b1);
    one("i_min",   3'd0, 7'h03, 5'd2, 5'd3, 5'd0, 3'd2, 32'hFFFFF800,  32'h8001A103, 1'b0);
    one("i_under", 3'd0, 7'h03, 5'd2, 5'd3, 5'd0, 3'd2, 32'hFFFFF7FF,  32'h7FF1A103, 1'b1);
    one("illegal", 3'd6, 7'h13, 5'd1, 5'd1, 5'd1, 3'd0, 32'd5,         32'h00000000, 1'b1);

`ifdef IMM_EXPAND_EN
    send(3'd0, 7'h13, 5'd5, 5'd0, 5'd0, 3'd0, 32'h00012345);
    in_valid = 1'b0;
    @(negedge clk);
    chk("exp_lui",   out_instr, 32'h000122B7);
    chk("exp_err1",  {31'd0, out_err}, 32'd0);
    chk("exp_rdy",   {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    chk("exp_addi",  out_instr, 32'h34528293);
    chk("exp_err2",  {31'd0, out_err}, 32'd0);
`else
    one("li_big",  3'd0, 7'h13, 5'd5, 5'd0, 5'd0, 3'd0, 32'h00012345,  32'h34500293, 1'b1);
`endif

    // Back-to-back stream with a 3-cycle consumer stall in the middle.
    @(posedge clk); #1;
    fork
      begin
        send(3'd0, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 32'd1);
        send(3'd0, 7'h13, 5'd2, 5'd0, 5'd0, 3'd0, 32'd2);
        send(3'd1, 7'h23, 5'd0, 5'd3, 5'd4, 3'd2, 32'd100);
        send(3'd3, 7'h37, 5'd7, 5'd0, 5'd0, 3'd0, 32'hABCDE000);
        in_valid = 1'b0;
      end
      begin
        repeat (2) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    repeat (4) @(negedge clk);
    chk("drain_vld", {31'd0, out_valid}, 32'd0);

    // Reset while a word (or expansion pair) is pending.
    @(posedge clk); #1;
    out_ready = 1'b0;
    send(3'd0, 7'h13, 5'd5, 5'd0, 5'd0, 3'd0, 32'h00012345);
    in_valid = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk("rst_async", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    one("post_rst", 3'd0, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 32'd10, 32'h00A00093, 1'b0);
    repeat (3) @(negedge clk);
    chk("end_vld", {31'd0, out_valid}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
